// File: rtl/odd_parity_tx.sv
// Odd-parity serial frame transmitter: DATA_W data bits LSB first, then a parity bit
// that makes the frame's count of ones odd. Define ODD_PARITY_TX_STOP_EN to append a stop bit.
module odd_parity_tx #(
   parameter int DATA_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic              ready,
   output logic              sout,
   output logic              sout_valid,
   output logic              frame_last,
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef ODD_PARITY_TX_STOP_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_e;
`endif

   state_e            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              par_q, par_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   // Outputs decode from registered state only; din/load only steer next state.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      par_d      = par_q;
      ready      = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      frame_last = 1'b0;
      busy       = 1'b1;
      case (state_q)
         IDLE: begin
            busy  = 1'b0;
            ready = 1'b1;
         end
         DATA: begin
            sout       = shreg_q[0];
            sout_valid = 1'b1;
            shreg_d    = shreg_q >> 1;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = PARITY;
         end
         PARITY: begin
            sout       = par_q;
            sout_valid = 1'b1;
`ifdef ODD_PARITY_TX_STOP_EN
            state_d    = STOP;
`else
            frame_last = 1'b1;
            ready      = 1'b1;
            state_d    = IDLE;
`endif
         end
`ifdef ODD_PARITY_TX_STOP_EN
         STOP: begin
            sout       = 1'b1;
            sout_valid = 1'b1;
            frame_last = 1'b1;
            ready      = 1'b1;
            state_d    = IDLE;
         end
`endif
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
         end
      endcase

      // Accepting in the frame's last cycle chains frames with no idle gap.
      if (load && ready) begin
         state_d = DATA;
         shreg_d = din;
         par_d   = ~^din;
         cnt_d   = '0;
      end
   end

endmodule

// File: tb/tb_odd_parity_tx.sv
// Randomized self-checking bench for odd_parity_tx: a queue-of-bits frame model checked
// every cycle, plus hand-computed literal frames.
module tb_odd_parity_tx;

   localparam int W = 3;
`ifdef ODD_PARITY_TX_STOP_EN
   localparam int FL  = W + 2;
   localparam int FL8 = 10;
`else
   localparam int FL  = W + 1;
   localparam int FL8 = 9;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] din = '0;
   logic         ready, sout, sout_valid, frame_last, busy;
   logic         load8 = 1'b0;
   logic [7:0]   din8 = '0;
   logic         ready8, sout8, sout_valid8, frame_last8, busy8;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   odd_parity_tx #(.DATA_W(W)) dut (
      .clk(clk), .reset(reset), .load(load), .din(din), .ready(ready), .sout(sout),
      .sout_valid(sout_valid), .frame_last(frame_last), .busy(busy));

   odd_parity_tx #(.DATA_W(8)) dut8 (
      .clk(clk), .reset(reset), .load(load8), .din(din8), .ready(ready8), .sout(sout8),
      .sout_valid(sout_valid8), .frame_last(frame_last8), .busy(busy8));

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the bits still to be sent in the current frame; front is on the line now.
   logic mq[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) mq.delete();
      else begin
         logic mready;
         mready = (mq.size() <= 1);
         if (mq.size() > 0) void'(mq.pop_front());
         if (load && mready) begin
            for (int i = 0; i < W; i++) mq.push_back(din[i]);
            mq.push_back(~^din);
`ifdef ODD_PARITY_TX_STOP_EN
            mq.push_back(1'b1);
`endif
         end
      end
   end

   always @(negedge clk) begin
      logic es;
      es = (mq.size() > 0) ? mq[0] : 1'b0;
      chk("sout",       16'(sout),       16'(es));
      chk("sout_valid", 16'(sout_valid), 16'(mq.size() > 0));
      chk("frame_last", 16'(frame_last), 16'(mq.size() == 1));
      chk("busy",       16'(busy),       16'(mq.size() > 0));
      chk("ready",      16'(ready),      16'(mq.size() <= 1));
   end

   // Sends d, then records n line bits; load=1 with inj_d is driven during cycle inj_c.
   task automatic send_cap(input logic [W-1:0] d, input int n, input int inj_c,
                           input logic [W-1:0] inj_d, output logic [15:0] cap);
      @(negedge clk); load = 1'b1; din = d;
      cap = '0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         cap[c] = sout;
         if (c == inj_c) begin load = 1'b1; din = inj_d; end
         else load = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] cap;
      int nv;
      repeat (3) @(negedge clk);
      chk("reset_ready", 16'(ready), 16'h1);
      chk("reset_valid", 16'(sout_valid), 16'h0);
      reset = 1'b1;

      send_cap(3'b000, FL, -1, 3'b000, cap);
`ifdef ODD_PARITY_TX_STOP_EN
      chk("frame_000", cap, 16'b11000);
`else
      chk("frame_000", cap, 16'b1000);
`endif
      @(negedge clk);
      chk("idle_after_valid", 16'(sout_valid), 16'h0);
      chk("idle_after_ready", 16'(ready), 16'h1);

      send_cap(3'b101, 2*FL, FL-1, 3'b111, cap);
`ifdef ODD_PARITY_TX_STOP_EN
      chk("b2b_101_111", cap, 16'b10_1111_1101);
`else
      chk("b2b_101_111", cap, 16'b0111_1101);
`endif

      repeat (2) @(negedge clk);
      send_cap(3'b001, FL, 1, 3'b110, cap);
`ifdef ODD_PARITY_TX_STOP_EN
      chk("ignored_load", cap, 16'b10001);
`else
      chk("ignored_load", cap, 16'b0001);
`endif
      @(negedge clk);
      chk("ignored_no_frame", 16'(sout_valid), 16'h0);

      send_cap(3'b010, FL, -1, 3'b000, cap);
`ifdef ODD_PARITY_TX_STOP_EN
      chk("frame_010", cap, 16'b10010);
`else
      chk("frame_010", cap, 16'b0010);
`endif

      // Asynchronous abort two bits into a frame.
      @(negedge clk); load = 1'b1; din = 3'b011;
      @(negedge clk); load = 1'b0;
      @(negedge clk);
      @(posedge clk); #3 reset = 1'b0;
      #1;
      chk("abort_sout",  16'(sout),       16'h0);
      chk("abort_valid", 16'(sout_valid), 16'h0);
      chk("abort_busy",  16'(busy),       16'h0);
      chk("abort_ready", 16'(ready),      16'h1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      send_cap(3'b100, FL, -1, 3'b000, cap);
`ifdef ODD_PARITY_TX_STOP_EN
      chk("after_abort_100", cap, 16'b10100);
`else
      chk("after_abort_100", cap, 16'b0100);
`endif

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 2) != 0);
         din  = W'($urandom);
         if ($urandom_range(0, 120) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk); reset = 1'b1;
         end
      end
      @(negedge clk); load = 1'b0;
      repeat (FL + 1) @(negedge clk);

      // Wide build: A5 has four ones, so parity is 1.
      load8 = 1'b1; din8 = 8'hA5;
      cap = '0; nv = 0;
      for (int c = 0; c < FL8; c++) begin
         @(negedge clk);
         load8 = 1'b0;
         cap[c] = sout8;
         nv += int'(sout_valid8);
      end
`ifdef ODD_PARITY_TX_STOP_EN
      chk("w8_frame_a5", cap, 16'h3A5);
`else
      chk("w8_frame_a5", cap, 16'h1A5);
`endif
      chk("w8_valid_cnt", 16'(nv), 16'(FL8));
      @(negedge clk);
      chk("w8_idle", 16'(sout_valid8), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/odd_parity_tx.md
Name: odd_parity_tx

Overview:
- Serial frame generator for the odd-parity link. Per frame it accepts one parallel DATA_W-bit word, shifts it out LSB first, then appends one odd-parity bit.
- Total ones per frame (data plus parity) is always odd.
- Sits on the transmit side, feeding the serial parity checker. Frame format is DATA_W data bits, LSB first, then the parity bit.

Parameters:
- DATA_W, 3, data bits per frame; legal range 1..16.

Ports:
- clk  input  1  system clock; rising edge only.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  request to send din; accepted when load && ready.
- din  input  DATA_W  parallel word; sampled only on the accept edge.
- ready  output  1  block can accept a word this cycle.
- sout  output  1  serial line bit.
- sout_valid  output  1  sout carries a frame bit (data, parity, or stop) this cycle.
- frame_last  output  1  high during the final bit of a frame.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0 except ready=1; shift register and counter cleared.
  - Reset mid-frame aborts the frame immediately. The remaining bits are never sent and are not resumed after reset release.
- States: IDLE, DATA, PARITY (plus STOP when the optional feature is enabled).
- IDLE:
  - ready=1, sout=0, sout_valid=0.
  - Accept: shreg<=din, par<=~^din (1 when din has an even count of ones), cnt<=0, go to DATA.
- DATA:
  - sout=shreg[0], sout_valid=1.
  - Each edge: shreg shifts right, cnt increments.
  - After DATA_W cycles (cnt==DATA_W-1 at the edge), go to PARITY.
- PARITY:
  - sout=par, sout_valid=1, frame_last=1 (stop disabled).
  - Next edge: go to IDLE, or go directly to DATA if a word is accepted that cycle.
- ready rule: ready=1 in IDLE and in the frame's last cycle (PARITY, or STOP if enabled); otherwise 0.
  - Accepting in the last cycle gives back-to-back frames with no idle bit between them.
- Latency: word accepted at edge N puts data bit 0 on sout in the cycle after edge N. Frame length is DATA_W+1 cycles.
- load while ready=0 is ignored. din is not sampled and there is no pending request.
- din changes after accept do not affect the frame in flight.
- Parity is computed on the captured word only; the combinational din path never reaches sout.
- DATA_W=1: DATA lasts exactly one cycle.
- Unreachable state encodings recover to IDLE on the next edge with outputs at reset values.
- All outputs are registered or decoded from state/shreg only; there is no combinational path from load/din to sout.

Optional Feature:
- Macro: ODD_PARITY_TX_STOP_EN.
- Defined:
  - STOP state follows PARITY: sout=1, sout_valid=1, frame_last=1 for one cycle.
  - frame_last is 0 in PARITY.
  - Frame length is DATA_W+2; ready is high in STOP instead of PARITY.
- Undefined: no STOP state; behaviour exactly as in Behaviour.

Test Plan:
- Reset released, load=1, din=3'b000 -> sout 0,0,0,1 on the 4 cycles after accept; sout_valid=1 for those 4 cycles; frame_last only on the 4th; then IDLE with sout_valid=0.
- din=3'b101, then 3'b111 back-to-back (load held through the first parity cycle) -> sout 1,0,1,1,1,1,1,0 continuous; ready high only in IDLE and on cycles 4 and 8.
- din=3'b001 accepted, then load=1 with din=3'b110 pulsed in DATA cycle 2 -> first frame 1,0,0,0 unaffected; second word ignored; ready=1 after the frame ends.
- Assert reset=0 asynchronously mid-DATA after 2 bits of din=3'b011 -> sout, sout_valid, busy drop to 0 immediately; ready=1; after release, the next accepted 3'b100 sends 0,0,1,0 cleanly.
- With ODD_PARITY_TX_STOP_EN defined, din=3'b010 -> sout 0,1,0,0,1 (parity 0, stop 1); frame_last only on the 5th bit.
- DATA_W=8 build, din=8'hA5 -> sout 1,0,1,0,0,1,0,1 then parity 1; 9 valid cycles.
